// File: rtl/pts_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pts_tx_pkg
// Description : Shared types and constants for the flex_pts_tx serial
//               transmitter. The PARITY state exists only when the
//               PTS_TX_PARITY_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package pts_tx_pkg;

    // Transmitter frame states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef PTS_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Level of the serial line between frames
    localparam logic c_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/flex_pts_sr.sv
`default_nettype none
// ============================================================================
// Module      : flex_pts_sr
// Description : Parameterised parallel-to-serial shift register. Load has
//               priority over shift; vacated positions fill with ones so the
//               register drifts toward the idle line level.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_pts_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);

    logic [NUM_BITS-1:0] r_data;
    logic [NUM_BITS-1:0] w_shifted;

    // Shift direction and tap selection depend on the transmit bit order
    generate
        if (SHIFT_MSB) begin : g_msb_first
            assign w_shifted  = {r_data[NUM_BITS-2:0], 1'b1};
            assign serial_out = r_data[NUM_BITS-1];
        end else begin : g_lsb_first
            assign w_shifted  = {1'b1, r_data[NUM_BITS-1:1]};
            assign serial_out = r_data[0];
        end
    endgenerate

    // Register: reset to all ones, load wins over shift
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_data <= '1;
        end else if (load_enable) begin
            r_data <= parallel_in;
        end else if (shift_enable) begin
            r_data <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flex_pts_tx.sv
`default_nettype none
// ============================================================================
// Module      : flex_pts_tx
// Description : Parallel-to-serial frame transmitter: start bit, NUM_BITS
//               data bits, optional even-parity bit, stop bit, each held
//               CLKS_PER_BIT clocks. Define PTS_TX_PARITY_EN to enable the
//               parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_pts_tx
    import pts_tx_pkg::*;
#(
    parameter int NUM_BITS     = 8,
    parameter bit SHIFT_MSB    = 1'b0,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam logic [7:0] c_CLK_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [4:0] c_BIT_LAST = 5'(NUM_BITS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_clk_cnt;
    logic [4:0] r_bit_cnt;
    logic       r_serial_out;
    logic       w_line_next;
    logic       w_load;
    logic       w_shift;
    logic       w_done;
    logic       w_boundary;
    logic       w_sr_out;
`ifdef PTS_TX_PARITY_EN
    logic       r_parity;
`endif

    assign w_boundary = (r_clk_cnt == c_CLK_LAST);
    assign tx_ready   = (r_state == IDLE) && n_rst;
    assign tx_busy    = (r_state != IDLE);
    assign tx_done    = w_done;
    assign serial_out = r_serial_out;

    // The register shifts as each data bit is driven, so its tap always
    // holds the next data bit to put on the line.
    flex_pts_sr #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_enable  (w_load),
        .shift_enable (w_shift),
        .parallel_in  (tx_data),
        .serial_out   (w_sr_out)
    );

    // State, line and counter registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_serial_out <= c_IDLE_LEVEL;
            r_clk_cnt    <= '1;
            r_bit_cnt    <= '1;
        end else begin
            r_state      <= w_state_next;
            r_serial_out <= w_line_next;
            if (w_load) begin
                r_clk_cnt <= '0;
                r_bit_cnt <= '0;
            end else if (r_state != IDLE) begin
                r_clk_cnt <= w_boundary ? 8'd0 : r_clk_cnt + 8'd1;
                if (r_state == DATA && w_boundary) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

`ifdef PTS_TX_PARITY_EN
    // Even parity of the word captured at acceptance
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_parity <= 1'b1;
        end else if (w_load) begin
            r_parity <= ^tx_data;
        end
    end
`endif

    // Next-state, next line level and control strobes
    always_comb begin
        w_state_next = r_state;
        w_line_next  = r_serial_out;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_line_next = c_IDLE_LEVEL;
                if (tx_valid) begin
                    w_state_next = START;
                    w_load       = 1'b1;
                    w_line_next  = 1'b0;
                end
            end
            START: begin
                if (w_boundary) begin
                    w_state_next = DATA;
                    w_shift      = 1'b1;
                    w_line_next  = w_sr_out;
                end
            end
            DATA: begin
                if (w_boundary) begin
                    if (r_bit_cnt == c_BIT_LAST) begin
`ifdef PTS_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_line_next  = r_parity;
`else
                        w_state_next = STOP;
                        w_line_next  = 1'b1;
`endif
                    end else begin
                        w_shift     = 1'b1;
                        w_line_next = w_sr_out;
                    end
                end
            end
`ifdef PTS_TX_PARITY_EN
            PARITY: begin
                if (w_boundary) begin
                    w_state_next = STOP;
                    w_line_next  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_boundary) begin
                    w_state_next = IDLE;
                    w_line_next  = c_IDLE_LEVEL;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_line_next  = c_IDLE_LEVEL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_flex_pts_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_flex_pts_tx
// Description : Testbench for flex_pts_tx. Three instances (LSB-first x4,
//               MSB-first x4, LSB-first x1) are compared cycle by cycle
//               against a frame model built from the framing rules.
//               Honours PTS_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flex_pts_tx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data    [3];
    logic       tx_valid   [3];
    logic       tx_ready   [3];
    logic       serial_out [3];
    logic       tx_busy    [3];
    logic       tx_done    [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .CLKS_PER_BIT(4)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .serial_out(serial_out[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .CLKS_PER_BIT(4)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .serial_out(serial_out[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .CLKS_PER_BIT(1)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .serial_out(serial_out[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

    function automatic int cpb_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one frame on instance k starting from a negedge in IDLE. Each
    // cycle's line level comes from a bit list built from the framing rules.
    // chain keeps tx_valid high into the next frame with word d_next;
    // abort_at > 0 returns right after checking that cycle.
    task automatic run_frame(input int k, input logic [7:0] d, input bit chain,
                             input logic [7:0] d_next, input int abort_at);
        bit q[$];
        bit b;
        int len;
        q = {};
        for (int j = 0; j < 12; j++) begin
            if (j == 0) b = 1'b0;
            else if (j <= 8) b = msb_of(k) ? d[8 - j] : d[j - 1];
            else if (j == 9) begin
`ifdef PTS_TX_PARITY_EN
                b = ^d;
`else
                continue;
`endif
            end else if (j == 10) b = 1'b1;
            else break;
            for (int c = 0; c < cpb_of(k); c++) q.push_back(b);
        end
        len = q.size();

        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        #1;
        chk($sformatf("ready_pre d%0d", k), 32'(tx_ready[k]), 32'd1);
        chk($sformatf("line_pre d%0d", k), 32'(serial_out[k]), 32'd1);
        chk($sformatf("busy_pre d%0d", k), 32'(tx_busy[k]), 32'd0);

        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            chk($sformatf("line d%0d c%0d", k, i), 32'(serial_out[k]), 32'(q[i-1]));
            chk($sformatf("busy d%0d c%0d", k, i), 32'(tx_busy[k]), 32'd1);
            chk($sformatf("done d%0d c%0d", k, i), 32'(tx_done[k]), 32'(i == len));
            chk($sformatf("ready d%0d c%0d", k, i), 32'(tx_ready[k]), 32'd0);
            if (i == abort_at) return;
            tx_data[k] = 8'($urandom);
            if (i == len) begin
                tx_valid[k] = chain;
                if (chain) tx_data[k] = d_next;
            end else begin
                tx_valid[k] = chain ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end

        @(negedge clk);
        chk($sformatf("line_gap d%0d", k), 32'(serial_out[k]), 32'd1);
        chk($sformatf("busy_gap d%0d", k), 32'(tx_busy[k]), 32'd0);
        chk($sformatf("done_gap d%0d", k), 32'(tx_done[k]), 32'd0);
        chk($sformatf("ready_gap d%0d", k), 32'(tx_ready[k]), 32'd1);
    endtask

    initial begin
        n_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tx_data[k]  = 8'h00;
            tx_valid[k] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_line d%0d", k), 32'(serial_out[k]), 32'd1);
            chk($sformatf("rst_busy d%0d", k), 32'(tx_busy[k]), 32'd0);
            chk($sformatf("rst_done d%0d", k), 32'(tx_done[k]), 32'd0);
            chk($sformatf("rst_ready d%0d", k), 32'(tx_ready[k]), 32'd0);
        end
        n_rst = 1'b1;
        @(negedge clk);

        // Directed words
        run_frame(0, 8'hA5, 1'b0, 8'h00, 0);
        run_frame(1, 8'h80, 1'b0, 8'h00, 0);
        run_frame(2, 8'hFF, 1'b0, 8'h00, 0);
        run_frame(0, 8'h07, 1'b0, 8'h00, 0);

        // Back-to-back with tx_valid held high
        run_frame(0, 8'h3C, 1'b1, 8'hC3, 0);
        run_frame(0, 8'hC3, 1'b0, 8'h00, 0);

        // Random words on every instance
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                run_frame(k, 8'($urandom), 1'b0, 8'h00, 0);
            end
        end

        // Abort during data bit 3 (cycles 17..20 after acceptance)
        run_frame(0, 8'h5A, 1'b0, 8'h00, 18);
        n_rst       = 1'b0;
        tx_valid[0] = 1'b1;
        tx_data[0]  = 8'($urandom);
        #1;
        chk("abort_ready_in_rst", 32'(tx_ready[0]), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_line", 32'(serial_out[0]), 32'd1);
            chk("abort_busy", 32'(tx_busy[0]), 32'd0);
            chk("abort_ready", 32'(tx_ready[0]), 32'd0);
            chk("abort_done", 32'(tx_done[0]), 32'd0);
        end
        n_rst = 1'b1;
        run_frame(0, 8'h96, 1'b0, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
